itlb_req_arbiter: RTL and testbench

ITLB_REQ_ARBITER -- requirements
Module: itlb_req_arbiter

---
 rtl/itlb_req_arbiter_if.sv | 38 +++
 rtl/itlb_req_arbiter.sv | 150 +++++++++++++++
 tb/tb_itlb_req_arbiter.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/itlb_req_arbiter_if.sv
// Signal bundle between the ITLB request arbiter and its fetch requesters / ITLB.
// master = arbiter side, slave = environment (requesters plus ITLB) side.
interface itlb_req_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int VPN_W   = 27,
    parameter int PPN_W   = 44,
    parameter int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*VPN_W-1:0] req_vpn;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     flush;
    logic                     tlb_valid;
    logic [VPN_W-1:0]         tlb_vpn;
    logic [IDW-1:0]           tlb_id;
    logic                     tlb_stall;
    logic                     tlb_res_valid;
    logic [IDW-1:0]           tlb_res_id;
    logic                     tlb_res_hit;
    logic [PPN_W-1:0]         tlb_res_ppn;
    logic [NUM_REQ-1:0]       rsp_valid;
    logic                     rsp_hit;
    logic [PPN_W-1:0]         rsp_ppn;

    modport master (
        input  req_valid, req_vpn, flush, tlb_stall,
        input  tlb_res_valid, tlb_res_id, tlb_res_hit, tlb_res_ppn,
        output req_ready, tlb_valid, tlb_vpn, tlb_id,
        output rsp_valid, rsp_hit, rsp_ppn
    );

    modport slave (
        output req_valid, req_vpn, flush, tlb_stall,
        output tlb_res_valid, tlb_res_id, tlb_res_hit, tlb_res_ppn,
        input  req_ready, tlb_valid, tlb_vpn, tlb_id,
        input  rsp_valid, rsp_hit, rsp_ppn
    );
endinterface

// File: rtl/itlb_req_arbiter.sv
// Shares one ITLB lookup port between NUM_REQ fetch requesters: age-ordered issue,
// id-tagged results routed back as one-cycle pulses, flush-safe result accounting.
module itlb_req_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int VPN_W   = 27,
    parameter int PPN_W   = 44
) (
    input  logic               clk,
    input  logic               rst_n,
    itlb_req_arbiter_if.master bus
);
    localparam int IDW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNTW = $clog2(NUM_REQ + 1);

    // Per-requester bookkeeping: accepted, sent to ITLB, result owed after flush.
    logic [NUM_REQ-1:0] busy_r;
    logic [NUM_REQ-1:0] issued_r;
    logic [NUM_REQ-1:0] ignore_r;
    logic [NUM_REQ-1:0] busy_n_s;
    logic [NUM_REQ-1:0] issued_n_s;
    logic [NUM_REQ-1:0] ignore_n_s;

    // Shift-down queue: slot 0 is always the oldest pending lookup.
    logic [IDW-1:0]     fifo_id_r    [NUM_REQ];
    logic [VPN_W-1:0]   fifo_vpn_r   [NUM_REQ];
    logic [IDW-1:0]     fifo_id_n_s  [NUM_REQ];
    logic [VPN_W-1:0]   fifo_vpn_n_s [NUM_REQ];
    logic [CNTW-1:0]    cnt_r;
    logic [CNTW-1:0]    cnt_n_s;
    int                 wr_pos_s;

    logic [NUM_REQ-1:0] rsp_valid_r;
    logic [NUM_REQ-1:0] rsp_valid_n_s;
    logic               rsp_hit_r;
    logic               rsp_hit_n_s;
    logic [PPN_W-1:0]   rsp_ppn_r;
    logic [PPN_W-1:0]   rsp_ppn_n_s;

    logic [NUM_REQ-1:0] req_ready_s;
    logic [NUM_REQ-1:0] accept_s;
    logic [NUM_REQ-1:0] head_oh_s;
    logic [NUM_REQ-1:0] issue_oh_s;
    logic [NUM_REQ-1:0] res_oh_s;
    logic [NUM_REQ-1:0] res_live_s;
    logic [NUM_REQ-1:0] res_ign_s;
    logic               tlb_valid_s;
    logic               pop_s;
    logic               deliver_s;

    // Handshake, issue and result decode, all from registered state plus flush.
    always_comb begin
        req_ready_s = ~busy_r & ~ignore_r & {NUM_REQ{~bus.flush}};
        accept_s    = bus.req_valid & req_ready_s;
        tlb_valid_s = (cnt_r != '0) && !bus.flush;
        pop_s       = tlb_valid_s && !bus.tlb_stall;
        for (int i = 0; i < NUM_REQ; i++) begin
            head_oh_s[i] = (fifo_id_r[0] == IDW'(i));
            res_oh_s[i]  = bus.tlb_res_valid && (bus.tlb_res_id == IDW'(i));
        end
        issue_oh_s = pop_s ? head_oh_s : '0;
        // A result matches at most one requester; it is live only if that one is issued.
        res_live_s = res_oh_s & issued_r & ~ignore_r;
        res_ign_s  = res_oh_s & ignore_r;
        deliver_s  = (res_live_s != '0) && !bus.flush;
    end

    // Queue update: pop shifts every entry down, new accepts append in index order.
    always_comb begin
        fifo_id_n_s  = fifo_id_r;
        fifo_vpn_n_s = fifo_vpn_r;
        for (int k = 0; k < NUM_REQ - 1; k++) begin
            fifo_id_n_s[k]  = pop_s ? fifo_id_r[k+1]  : fifo_id_r[k];
            fifo_vpn_n_s[k] = pop_s ? fifo_vpn_r[k+1] : fifo_vpn_r[k];
        end
        wr_pos_s = int'(cnt_r) - int'(pop_s);
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                fifo_id_n_s[k]  = (accept_s[i] && (k == wr_pos_s)) ? IDW'(i) : fifo_id_n_s[k];
                fifo_vpn_n_s[k] = (accept_s[i] && (k == wr_pos_s)) ?
                                  bus.req_vpn[i*VPN_W +: VPN_W] : fifo_vpn_n_s[k];
            end
            wr_pos_s = wr_pos_s + int'(accept_s[i]);
        end
        if (bus.flush) begin
            cnt_n_s = '0;
        end else begin
            cnt_n_s = CNTW'(wr_pos_s);
        end
    end

    // Requester status and response next-state.
    always_comb begin
        if (bus.flush) begin
            // In-flight lookups become owed results unless their result is consumed now.
            busy_n_s   = '0;
            issued_n_s = '0;
            ignore_n_s = (ignore_r | issued_r) & ~res_oh_s;
        end else begin
            busy_n_s   = (busy_r | accept_s) & ~res_live_s;
            issued_n_s = (issued_r | issue_oh_s) & ~(res_live_s | res_ign_s);
            ignore_n_s = ignore_r & ~res_ign_s;
        end
        if (deliver_s) begin
            rsp_valid_n_s = res_live_s;
            rsp_hit_n_s   = bus.tlb_res_hit;
            rsp_ppn_n_s   = bus.tlb_res_ppn;
        end else begin
            rsp_valid_n_s = '0;
            rsp_hit_n_s   = rsp_hit_r;
            rsp_ppn_n_s   = rsp_ppn_r;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_r      <= '0;
            issued_r    <= '0;
            ignore_r    <= '0;
            cnt_r       <= '0;
            rsp_valid_r <= '0;
            rsp_hit_r   <= 1'b0;
            rsp_ppn_r   <= '0;
            for (int k = 0; k < NUM_REQ; k++) begin
                fifo_id_r[k]  <= '0;
                fifo_vpn_r[k] <= '0;
            end
        end else begin
            busy_r      <= busy_n_s;
            issued_r    <= issued_n_s;
            ignore_r    <= ignore_n_s;
            cnt_r       <= cnt_n_s;
            rsp_valid_r <= rsp_valid_n_s;
            rsp_hit_r   <= rsp_hit_n_s;
            rsp_ppn_r   <= rsp_ppn_n_s;
            for (int k = 0; k < NUM_REQ; k++) begin
                fifo_id_r[k]  <= fifo_id_n_s[k];
                fifo_vpn_r[k] <= fifo_vpn_n_s[k];
            end
        end
    end

    assign bus.req_ready = req_ready_s;
    assign bus.tlb_valid = tlb_valid_s;
    assign bus.tlb_vpn   = fifo_vpn_r[0];
    assign bus.tlb_id    = fifo_id_r[0];
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_hit   = rsp_hit_r;
    assign bus.rsp_ppn   = rsp_ppn_r;
endmodule

// File: tb/tb_itlb_req_arbiter.sv
// Scoreboard bench for itlb_req_arbiter: a per-requester status model predicts lookups,
// readiness and responses; a negedge monitor compares the DUT against those queues.
module tb_itlb_req_arbiter;
    localparam int NUM_REQ = 4;
    localparam int VPN_W   = 27;
    localparam int PPN_W   = 44;
    localparam int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam int S_IDLE   = 0;
    localparam int S_QUEUED = 1;
    localparam int S_INFL   = 2;
    localparam int S_IGN    = 3;

    typedef struct { int id; logic [VPN_W-1:0] vpn; int vis; } look_t;
    typedef struct { int id; logic hit; logic [PPN_W-1:0] ppn; int due; } rsp_t;

    logic clk;
    logic rst_n;

    itlb_req_arbiter_if #(.NUM_REQ(NUM_REQ), .VPN_W(VPN_W), .PPN_W(PPN_W)) bus ();

    itlb_req_arbiter #(.NUM_REQ(NUM_REQ), .VPN_W(VPN_W), .PPN_W(PPN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Reference model: requester status, order of queued ids, ids outstanding at the ITLB.
    int st [NUM_REQ];
    int mq [$];
    int itlb_q [$];
    look_t sb_look [$];
    rsp_t  exp_rsp [$];
    logic [NUM_REQ-1:0] exp_ready;
    logic last_hit;
    logic [PPN_W-1:0] last_ppn;
    logic [NUM_REQ*VPN_W-1:0] vpn_bus;

    logic mon_exp_v;
    logic [NUM_REQ-1:0] mon_rsp_vec;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Drive one cycle of stimulus, advance the model across the coming edge.
    task automatic step(input logic f, input logic s, input logic [NUM_REQ-1:0] rv,
                        input logic rvld, input int rid, input logic hit,
                        input logic [PPN_W-1:0] ppn);
        look_t le;
        rsp_t  re;
        int    h;
        bus.flush         = f;
        bus.tlb_stall     = s;
        bus.req_valid     = rv;
        bus.req_vpn       = vpn_bus;
        bus.tlb_res_valid = rvld;
        bus.tlb_res_id    = IDW'(rid);
        bus.tlb_res_hit   = hit;
        bus.tlb_res_ppn   = ppn;
        for (int i = 0; i < NUM_REQ; i++) exp_ready[i] = (st[i] == S_IDLE) && !f;
        if (rvld && (st[rid] == S_IGN || st[rid] == S_INFL)) begin
            for (int j = 0; j < itlb_q.size(); j++) begin
                if (itlb_q[j] == rid) begin
                    itlb_q.delete(j);
                    break;
                end
            end
            if (st[rid] == S_INFL && !f) begin
                re.id = rid; re.hit = hit; re.ppn = ppn; re.due = cyc + 1;
                exp_rsp.push_back(re);
            end
            st[rid] = S_IDLE;
        end
        if (f) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (st[i] == S_INFL) st[i] = S_IGN;
                else if (st[i] == S_QUEUED) st[i] = S_IDLE;
            end
            mq.delete();
            sb_look.delete();
        end else begin
            if (mq.size() > 0 && !s) begin
                h = mq.pop_front();
                st[h] = S_INFL;
                itlb_q.push_back(h);
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (rv[i] && exp_ready[i]) begin
                    st[i] = S_QUEUED;
                    mq.push_back(i);
                    le.id = i; le.vpn = vpn_bus[i*VPN_W +: VPN_W]; le.vis = cyc + 1;
                    sb_look.push_back(le);
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, '0, 1'b0, 0, 1'b0, '0);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        bus.req_valid = '0; bus.req_vpn = '0; bus.flush = 1'b0; bus.tlb_stall = 1'b0;
        bus.tlb_res_valid = 1'b0; bus.tlb_res_id = '0; bus.tlb_res_hit = 1'b0;
        bus.tlb_res_ppn = '0;
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) st[i] = S_IDLE;
        mq.delete(); itlb_q.delete(); sb_look.delete(); exp_rsp.delete();
        last_hit = 1'b0;
        last_ppn = '0;
    endtask

    // Return every outstanding result (bounded) so the next scenario starts from idle.
    task automatic drain();
        for (int c = 0; c < 200 && (mq.size() > 0 || itlb_q.size() > 0); c++) begin
            if (itlb_q.size() > 0)
                step(1'b0, 1'b0, '0, 1'b1, itlb_q[0], 1'($urandom), PPN_W'({$urandom, $urandom}));
            else
                idle(1);
        end
        idle(1);
    endtask

    function automatic void set_vpn(input int i, input logic [VPN_W-1:0] v);
        vpn_bus[i*VPN_W +: VPN_W] = v;
    endfunction

    // Monitor: compare DUT outputs against model expectations mid-cycle.
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            chk("req_ready", 64'(bus.req_ready), 64'(exp_ready));
            mon_exp_v = !bus.flush && (sb_look.size() > 0) && (sb_look[0].vis <= cyc);
            chk("tlb_valid", 64'(bus.tlb_valid), 64'(mon_exp_v));
            if (mon_exp_v) begin
                chk("tlb_id", 64'(bus.tlb_id), 64'(sb_look[0].id));
                chk("tlb_vpn", 64'(bus.tlb_vpn), 64'(sb_look[0].vpn));
                if (!bus.tlb_stall) void'(sb_look.pop_front());
            end
            if (exp_rsp.size() > 0 && exp_rsp[0].due == cyc) begin
                for (int i = 0; i < NUM_REQ; i++) mon_rsp_vec[i] = (exp_rsp[0].id == i);
                chk("rsp_valid", 64'(bus.rsp_valid), 64'(mon_rsp_vec));
                chk("rsp_hit", 64'(bus.rsp_hit), 64'(exp_rsp[0].hit));
                chk("rsp_ppn", 64'(bus.rsp_ppn), 64'(exp_rsp[0].ppn));
                last_hit = exp_rsp[0].hit;
                last_ppn = exp_rsp[0].ppn;
                void'(exp_rsp.pop_front());
            end else begin
                chk("rsp_valid_idle", 64'(bus.rsp_valid), 64'(0));
                chk("rsp_hold", 64'({bus.rsp_hit, bus.rsp_ppn}), 64'({last_hit, last_ppn}));
            end
        end
    end

    initial begin
        logic f;
        logic s;
        logic [NUM_REQ-1:0] rv;
        logic rvld;
        int rid;
        int idx;
        rst_n = 1'b0;
        vpn_bus = '0;
        do_reset(3);
        chk_en = 1'b1;
        idle(1);

        // Single lookup: id 2, result three cycles after the request.
        set_vpn(2, 27'h1234);
        step(1'b0, 1'b0, 4'b0100, 1'b0, 0, 1'b0, '0);
        idle(2);
        step(1'b0, 1'b0, '0, 1'b1, 2, 1'b1, 44'hABC);
        idle(2);

        // Age ordering: 3 first, then 0 and 1 together.
        step(1'b0, 1'b0, 4'b1000, 1'b0, 0, 1'b0, '0);
        step(1'b0, 1'b0, 4'b0011, 1'b0, 0, 1'b0, '0);
        idle(3);
        drain();

        // Stall holds the head for three cycles.
        set_vpn(0, 27'h00AAA); set_vpn(1, 27'h00BBB);
        step(1'b0, 1'b0, 4'b0011, 1'b0, 0, 1'b0, '0);
        repeat (3) step(1'b0, 1'b1, '0, 1'b0, 0, 1'b0, '0);
        idle(2);
        drain();

        // Flush with id 1 in flight and id 2 queued; id 1 result later dropped.
        step(1'b0, 1'b0, 4'b0010, 1'b0, 0, 1'b0, '0);
        idle(1);
        step(1'b0, 1'b0, 4'b0100, 1'b0, 0, 1'b0, '0);
        step(1'b1, 1'b0, '0, 1'b0, 0, 1'b0, '0);
        idle(2);
        step(1'b0, 1'b0, '0, 1'b1, 1, 1'b1, 44'h123);
        idle(2);

        // Result for id 0 coincident with flush.
        step(1'b0, 1'b0, 4'b0001, 1'b0, 0, 1'b0, '0);
        idle(1);
        step(1'b1, 1'b0, '0, 1'b1, 0, 1'b1, 44'h777);
        idle(2);

        // Back-pressure: requester 0 keeps asking while busy.
        repeat (3) step(1'b0, 1'b0, 4'b0001, 1'b0, 0, 1'b0, '0);
        step(1'b0, 1'b0, 4'b0001, 1'b1, 0, 1'b0, 44'h55);
        step(1'b0, 1'b0, 4'b0001, 1'b0, 0, 1'b0, '0);
        drain();

        // Randomized traffic with one reset in the middle.
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                do_reset(2);
            end
            f = ($urandom_range(0, 29) == 0);
            s = ($urandom_range(0, 3) == 0);
            rv = NUM_REQ'($urandom);
            for (int i = 0; i < NUM_REQ; i++) set_vpn(i, VPN_W'($urandom));
            rvld = 1'b0;
            rid = 0;
            if (itlb_q.size() > 0 && $urandom_range(0, 9) < 6) begin
                idx = $urandom_range(0, itlb_q.size() - 1);
                rid = itlb_q[idx];
                rvld = 1'b1;
            end else if ($urandom_range(0, 15) == 0) begin
                rid = $urandom_range(0, NUM_REQ - 1);
                rvld = (st[rid] == S_IDLE) || (st[rid] == S_QUEUED);
            end
            step(f, s, rv, rvld, rid, 1'($urandom), PPN_W'({$urandom, $urandom}));
        end
        drain();
        idle(2);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
